// File: rtl/s16_fetch_sequencer_if.sv
// rtl/s16_fetch_sequencer_if.sv - bus master and execute-side signals of the fetch sequencer
interface s16_fetch_sequencer_if #(
    parameter int ADR_W  = 15,
    parameter int DAT_W  = 16,
    parameter int SLOT_W = 4
);
    logic [ADR_W-1:0]   adr_o;
    logic               cyc_o;
    logic [DAT_W/8-1:0] stb_o;
    logic               we_o;
    logic               vpa_o;
    logic               vda_o;
    logic               ack_i;
    logic [DAT_W-1:0]   dat_i;
    logic [SLOT_W-1:0]  op_o;
    logic               op_valid_o;
    logic               op_ready_i;
    logic [DAT_W-1:0]   lit_o;
    logic               redirect_i;
    logic [ADR_W-1:0]   redirect_adr_i;

    modport master (
        output adr_o, cyc_o, stb_o, we_o, vpa_o, vda_o, op_o, op_valid_o, lit_o,
        input  ack_i, dat_i, op_ready_i, redirect_i, redirect_adr_i
    );

    modport slave (
        input  adr_o, cyc_o, stb_o, we_o, vpa_o, vda_o, op_o, op_valid_o, lit_o,
        output ack_i, dat_i, op_ready_i, redirect_i, redirect_adr_i
    );
endinterface

// File: rtl/s16_fetch_sequencer.sv
// rtl/s16_fetch_sequencer.sv - instruction fetch and opcode slot sequencer for Steamer-class stack CPUs
module s16_fetch_sequencer #(
    parameter int          ADR_W             = 15,
    parameter int          DAT_W             = 16,
    parameter int          SLOT_W            = 4,
    parameter int          LIT_OP            = 1,
    parameter int          NOP_OP            = 0,
    parameter int unsigned RESET_ADR         = 32'hFFF0,
    parameter bit          SKIP_TRAILING_NOP = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   res_i,
    s16_fetch_sequencer_if.master  bus
);
    localparam int SLOTS = DAT_W / SLOT_W;
    localparam int CNT_W = $clog2(SLOTS + 1);
    localparam logic [SLOT_W-1:0] LIT   = SLOT_W'(LIT_OP);
    localparam logic [SLOT_W-1:0] NOP   = SLOT_W'(NOP_OP);
    localparam logic [ADR_W-1:0]  P_RST = ADR_W'(RESET_ADR >> 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(SLOTS);

    typedef enum logic [1:0] {FETCH, DISPATCH, OPERAND} state_t;

    state_t            state_q, state_d;
    logic [ADR_W-1:0]  p_q, p_d;
    logic [DAT_W-1:0]  ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DAT_W-1:0]  ir_shift;
    logic [CNT_W-1:0]  cnt_inc;
    state_t            consume_state;

    // Only the slots not yet consumed take part in the trailing-NOP test,
    // so zero fill from the shift never masquerades as a NOP.
    function automatic state_t next_of(input logic [DAT_W-1:0] w, input logic [CNT_W-1:0] used);
        logic all_nop;
        all_nop = 1'b1;
        for (int i = 0; i < SLOTS; i++) begin
            if (i < SLOTS - int'(used) && w[DAT_W-1-i*SLOT_W -: SLOT_W] != NOP)
                all_nop = 1'b0;
        end
        if (w[DAT_W-1 -: SLOT_W] == LIT)
            return OPERAND;
        else if (SKIP_TRAILING_NOP && used != '0 && all_nop)
            return FETCH;
        else
            return DISPATCH;
    endfunction

    assign ir_shift      = ir_q << SLOT_W;
    assign cnt_inc       = cnt_q + 1'b1;
    assign consume_state = (cnt_inc == LAST) ? FETCH : next_of(ir_shift, cnt_inc);

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            state_q <= FETCH;
            p_q     <= P_RST;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        p_d            = p_q;
        ir_d           = ir_q;
        cnt_d          = cnt_q;
        bus.cyc_o      = 1'b0;
        bus.vpa_o      = 1'b0;
        bus.vda_o      = 1'b0;
        bus.op_valid_o = 1'b0;
        bus.op_o       = ir_q[DAT_W-1 -: SLOT_W];
        case (state_q)
            FETCH: begin
                bus.cyc_o = 1'b1;
                bus.vpa_o = 1'b1;
                if (bus.ack_i) begin
                    ir_d    = bus.dat_i;
                    p_d     = p_q + 1'b1;
                    cnt_d   = '0;
                    state_d = next_of(bus.dat_i, '0);
                end
            end
            DISPATCH: begin
                bus.op_valid_o = 1'b1;
                if (bus.op_ready_i) begin
                    ir_d    = ir_shift;
                    cnt_d   = cnt_inc;
                    state_d = consume_state;
                end
            end
            OPERAND: begin
                bus.cyc_o      = 1'b1;
                bus.vpa_o      = 1'b1;
                bus.vda_o      = 1'b1;
                bus.op_o       = LIT;
                bus.op_valid_o = bus.ack_i;
                // An ack without op_ready leaves the cycle open, so the read repeats.
                if (bus.ack_i && bus.op_ready_i) begin
                    p_d     = p_q + 1'b1;
                    ir_d    = ir_shift;
                    cnt_d   = cnt_inc;
                    state_d = consume_state;
                end
            end
            default: state_d = FETCH;
        endcase
        if (bus.redirect_i) begin
            p_d     = bus.redirect_adr_i;
            ir_d    = '0;
            cnt_d   = '0;
            state_d = FETCH;
        end
    end

    assign bus.adr_o = p_q;
    assign bus.stb_o = {(DAT_W/8){bus.cyc_o}};
    assign bus.we_o  = 1'b0;
    assign bus.lit_o = bus.dat_i;
endmodule

// File: tb/tb_s16_fetch_sequencer.sv
// tb/tb_s16_fetch_sequencer.sv - self-checking bench for s16_fetch_sequencer
module tb_s16_fetch_sequencer;
    logic clk = 1'b0;
    logic res;
    logic res32;
    int   vectors;
    int   miscompares;

    always #5 clk = ~clk;

    s16_fetch_sequencer_if #(.ADR_W(15), .DAT_W(16), .SLOT_W(4)) bus ();
    s16_fetch_sequencer_if #(.ADR_W(15), .DAT_W(32), .SLOT_W(5)) bus32 ();

    logic [15:0] mem [0:32767];
    assign bus.dat_i = mem[bus.adr_o];

    s16_fetch_sequencer dut (
        .clk_i (clk),
        .res_i (res),
        .bus   (bus)
    );

    s16_fetch_sequencer #(.DAT_W(32), .SLOT_W(5), .LIT_OP(31)) dut32 (
        .clk_i (clk),
        .res_i (res32),
        .bus   (bus32)
    );

    // Snapshot {cyc, vpa, vda, op_valid, op, adr}; op and adr only count where they are defined.
    function automatic logic [22:0] snap();
        return {bus.cyc_o, bus.vpa_o, bus.vda_o, bus.op_valid_o,
                bus.op_valid_o ? bus.op_o : 4'h0, bus.cyc_o ? bus.adr_o : 15'h0};
    endfunction

    function automatic logic [22:0] ex(input logic c, input logic pa, input logic da, input logic v,
                                       input logic [3:0] op, input logic [14:0] a);
        return {c, pa, da, v, v ? op : 4'h0, c ? a : 15'h0};
    endfunction

    task automatic start(input logic a, input logic r);
        res = 1'b1;
        bus.ack_i = a;
        bus.op_ready_i = r;
        bus.redirect_i = 1'b0;
        @(posedge clk); #1;
        res = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b1;
        mem[15'h7FF8] = 16'h1000;
        bus.ack_i = 1'b1;
        bus.op_ready_i = 1'b1;
        #2;
        vectors++;
        if (snap() !== ex(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 15'h7FF8) || bus.stb_o !== 2'b11 || bus.we_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h stb %b we %b want %h stb 11 we 0", snap(), bus.stb_o, bus.we_o,
                     ex(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 15'h7FF8));
        end
        @(posedge clk); @(posedge clk); @(negedge clk);
        vectors++;
        if (snap() !== ex(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 15'h7FF8)) begin
            miscompares++;
            $display("FAIL reset_ignores_ack got %h want %h", snap(), ex(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 15'h7FF8));
        end
    endtask

    task automatic test_literal_timing();
        logic [22:0] exp [3];
        mem[15'h7FF8] = 16'h1000;
        mem[15'h7FF9] = 16'hABCD;
        mem[15'h7FFA] = 16'h0000;
        exp[0] = ex(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 15'h7FF8);
        exp[1] = ex(1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 15'h7FF9);
        exp[2] = ex(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 15'h7FFA);
        start(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (snap() !== exp[i] || bus.stb_o !== 2'b11) begin
                miscompares++;
                $display("FAIL literal_cycle%0d got %h stb %b want %h stb 11", i, snap(), bus.stb_o, exp[i]);
            end
            if (i == 1) begin
                vectors++;
                if (bus.lit_o !== 16'hABCD) begin
                    miscompares++;
                    $display("FAIL literal_lit got %h want abcd", bus.lit_o);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wait_states();
        logic [22:0] exp [5];
        mem[15'h7FF8] = 16'h1000;
        mem[15'h7FF9] = 16'h1234;
        for (int i = 0; i < 4; i++) exp[i] = ex(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 15'h7FF8);
        exp[4] = ex(1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 15'h7FF9);
        start(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus.ack_i = (i >= 3);
            @(negedge clk);
            vectors++;
            if (snap() !== exp[i]) begin
                miscompares++;
                $display("FAIL wait_cycle%0d got %h want %h", i, snap(), exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_nop_skip();
        logic [22:0] exp [5];
        mem[15'h7FF8] = 16'h0010;
        mem[15'h7FF9] = 16'h5555;
        mem[15'h7FFA] = 16'h0000;
        exp[0] = ex(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 15'h7FF8);
        exp[1] = ex(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 15'h0);
        exp[2] = ex(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 15'h0);
        exp[3] = ex(1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 15'h7FF9);
        exp[4] = ex(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 15'h7FFA);
        start(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (snap() !== exp[i] || bus.stb_o !== {2{exp[i][22]}}) begin
                miscompares++;
                $display("FAIL nop_skip_cycle%0d got %h stb %b want %h", i, snap(), bus.stb_o, exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ready_stall();
        logic [22:0] exp [7];
        logic        rdy [7];
        mem[15'h7FF8] = 16'h2340;
        mem[15'h7FF9] = 16'h0000;
        exp[0] = ex(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 15'h7FF8);
        exp[1] = ex(1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 15'h0);
        exp[2] = exp[1];
        exp[3] = exp[1];
        exp[4] = ex(1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 15'h0);
        exp[5] = ex(1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 15'h0);
        exp[6] = ex(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 15'h7FF9);
        rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        start(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            bus.op_ready_i = rdy[i];
            @(negedge clk);
            vectors++;
            if (snap() !== exp[i]) begin
                miscompares++;
                $display("FAIL stall_cycle%0d got %h want %h", i, snap(), exp[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        mem[15'h7FF8] = 16'h1000;
        mem[15'h7FF9] = 16'hBEEF;
        mem[15'h0123] = 16'h0000;
        start(1'b1, 1'b1);
        @(posedge clk); #1;
        bus.redirect_i = 1'b1;
        bus.redirect_adr_i = 15'h0123;
        @(negedge clk);
        vectors++;
        if (snap() !== ex(1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 15'h7FF9)) begin
            miscompares++;
            $display("FAIL redirect_operand got %h want %h", snap(), ex(1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 15'h7FF9));
        end
        @(posedge clk); #1;
        bus.redirect_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (snap() !== ex(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 15'h0123)) begin
            miscompares++;
            $display("FAIL redirect_target got %h want %h", snap(), ex(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 15'h0123));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_operand();
        mem[15'h7FF8] = 16'h1000;
        mem[15'h7FF9] = 16'h4444;
        start(1'b1, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (snap() !== ex(1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 15'h7FF9)) begin
            miscompares++;
            $display("FAIL midreset_before got %h want %h", snap(), ex(1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 15'h7FF9));
        end
        #1 res = 1'b1;
        #1;
        vectors++;
        if (snap() !== ex(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 15'h7FF8)) begin
            miscompares++;
            $display("FAIL midreset_after got %h want %h", snap(), ex(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 15'h7FF8));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wide();
        logic [31:0] w32;
        int          kind [8];
        logic [4:0]  eop [8];
        logic [14:0] eadr [8];
        w32  = {5'd2, 5'd3, 5'd4, 5'd31, 5'd6, 5'd7, 2'b00};
        kind = '{0, 1, 1, 1, 2, 1, 1, 0};
        eop  = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd31, 5'd6, 5'd7, 5'd0};
        eadr = '{15'h7FF8, 15'h0, 15'h0, 15'h0, 15'h7FF9, 15'h0, 15'h0, 15'h7FFA};
        res32 = 1'b1;
        bus32.ack_i = 1'b1;
        bus32.op_ready_i = 1'b1;
        bus32.redirect_i = 1'b0;
        bus32.dat_i = w32;
        @(posedge clk); #1;
        res32 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus32.dat_i = (kind[i] == 2) ? 32'hDEADBEEF : w32;
            @(negedge clk);
            vectors++;
            if (bus32.cyc_o !== (kind[i] != 1) || bus32.vda_o !== (kind[i] == 2) ||
                bus32.op_valid_o !== (kind[i] != 0) || bus32.stb_o !== ((kind[i] != 1) ? 4'hF : 4'h0) ||
                (kind[i] != 0 && bus32.op_o !== eop[i]) || (kind[i] != 1 && bus32.adr_o !== eadr[i]) ||
                (kind[i] == 2 && bus32.lit_o !== 32'hDEADBEEF)) begin
                miscompares++;
                $display("FAIL wide_cycle%0d got cyc %b vda %b valid %b stb %h op %h adr %h want kind %0d op %h adr %h",
                         i, bus32.cyc_o, bus32.vda_o, bus32.op_valid_o, bus32.stb_o, bus32.op_o, bus32.adr_o,
                         kind[i], eop[i], eadr[i]);
            end
            @(posedge clk); #1;
        end
        res32 = 1'b1;
    endtask

    // Reference: each fetched word expands into a list of slot events; 16 marks a literal.
    task automatic test_random();
        logic [14:0] mp;
        logic [15:0] w;
        logic [3:0]  s;
        logic        rest_nop;
        int          pend [$];
        for (int a = 0; a < 32768; a++) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
                case ($urandom_range(0, 3))
                    0: s = 4'h0;
                    1: s = 4'h1;
                    default: s = 4'($urandom_range(0, 15));
                endcase
                w[15-4*k -: 4] = s;
            end
            mem[a] = w;
        end
        start(1'b0, 1'b0);
        mp = 15'h7FF8;
        for (int c = 0; c < 3000; c++) begin
            bus.ack_i = ($urandom_range(0, 3) != 0);
            bus.op_ready_i = ($urandom_range(0, 3) != 0);
            bus.redirect_i = ($urandom_range(0, 63) == 0);
            bus.redirect_adr_i = 15'($urandom);
            @(negedge clk);
            vectors++;
            if (bus.stb_o !== {2{bus.cyc_o}} || bus.we_o !== 1'b0) begin
                miscompares++;
                $display("FAIL rand_strobe cycle %0d got stb %b we %b cyc %b", c, bus.stb_o, bus.we_o, bus.cyc_o);
            end
            if (bus.redirect_i) begin
                mp = bus.redirect_adr_i;
                pend.delete();
            end else if (bus.cyc_o && !bus.vda_o) begin
                vectors++;
                if (pend.size() != 0 || bus.adr_o !== mp || bus.op_valid_o !== 1'b0 || bus.vpa_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rand_fetch cycle %0d got adr %h valid %b pending %0d want adr %h pending 0",
                             c, bus.adr_o, bus.op_valid_o, pend.size(), mp);
                    pend.delete();
                end
                if (bus.ack_i) begin
                    w = mem[mp];
                    mp++;
                    for (int k = 0; k < 4; k++) begin
                        s = w[15-4*k -: 4];
                        if (s == 4'h1) begin
                            pend.push_back(16);
                        end else begin
                            rest_nop = 1'b1;
                            for (int j = k; j < 4; j++) if (w[15-4*j -: 4] != 4'h0) rest_nop = 1'b0;
                            if (k > 0 && rest_nop) break;
                            pend.push_back(int'(s));
                        end
                    end
                end
            end else if (bus.cyc_o && bus.vda_o) begin
                vectors++;
                if (pend.size() == 0 || pend[0] != 16 || bus.adr_o !== mp || bus.op_valid_o !== bus.ack_i ||
                    bus.op_o !== 4'h1 || bus.vpa_o !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rand_operand cycle %0d got adr %h op %h valid %b want adr %h literal pending %0d",
                             c, bus.adr_o, bus.op_o, bus.op_valid_o, mp, pend.size());
                end
                if (bus.ack_i && bus.op_ready_i) begin
                    vectors++;
                    if (bus.lit_o !== mem[mp]) begin
                        miscompares++;
                        $display("FAIL rand_lit cycle %0d got %h want %h", c, bus.lit_o, mem[mp]);
                    end
                    if (pend.size() > 0) void'(pend.pop_front());
                    mp++;
                end
            end else begin
                vectors++;
                if (pend.size() == 0 || pend[0] == 16 || bus.op_valid_o !== 1'b1 || bus.vpa_o !== 1'b0 ||
                    bus.vda_o !== 1'b0 || int'(bus.op_o) != pend[0]) begin
                    miscompares++;
                    $display("FAIL rand_dispatch cycle %0d got op %h valid %b want op %0d pending %0d",
                             c, bus.op_o, bus.op_valid_o, (pend.size() > 0) ? pend[0] : -1, pend.size());
                end
                if (bus.op_ready_i && pend.size() > 0) void'(pend.pop_front());
            end
            @(posedge clk); #1;
        end
        bus.ack_i = 1'b0;
        bus.redirect_i = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        res = 1'b1;
        res32 = 1'b1;
        bus.ack_i = 1'b0;
        bus.op_ready_i = 1'b0;
        bus.redirect_i = 1'b0;
        bus.redirect_adr_i = '0;
        bus32.ack_i = 1'b0;
        bus32.op_ready_i = 1'b0;
        bus32.redirect_i = 1'b0;
        bus32.redirect_adr_i = '0;
        bus32.dat_i = '0;
        for (int a = 0; a < 32768; a++) mem[a] = 16'h0000;
        test_reset();
        test_literal_timing();
        test_wait_states();
        test_nop_skip();
        test_ready_stall();
        test_redirect();
        test_reset_mid_operand();
        test_wide();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
